// File: rtl/pool_stream_ctrl.sv
// Frame sequencer for one pooling_layer: gates its clk_en per accepted pixel and buffers pooled outputs.
// Define POOL_CTRL_PERF_EN to add the stall/frame cycle counters and the sticky overflow output.
module pool_stream_ctrl #(
  parameter int CHANNELS    = 5,
  parameter int I_WIDTH     = 16,
  parameter int IMAGE_SIZE  = 15,
  parameter int FILTER_SIZE = 2,
  parameter int STRIDE      = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CHANNELS*I_WIDTH-1:0]  in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         pool_clk_en,
  output logic [CHANNELS*I_WIDTH-1:0]  pool_in_data,
  input  logic [CHANNELS*I_WIDTH-1:0]  pool_data,
  input  logic                         pool_valid,
  output logic [CHANNELS*I_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
`ifdef POOL_CTRL_PERF_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  frame_cycles,
  output logic                         overflow
`endif
);

  localparam int W        = CHANNELS * I_WIDTH;
  localparam int N_IN     = IMAGE_SIZE * IMAGE_SIZE;
  localparam int OUT_SIDE = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int N_OUT    = OUT_SIDE * OUT_SIDE;
  localparam int IN_CW    = $clog2(N_IN);
  localparam int OUT_CW   = $clog2(N_OUT + 1);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [IN_CW-1:0]    in_cnt;
  logic [OUT_CW-1:0]   out_cnt;
  logic                cap_pending;
  logic                ovf;
  logic [W:0]          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         occupancy;
  logic [W:0]          head;
  logic                frame_start, last_accept, capture, push, pop, fifo_empty, last_cap;

  // A capture already in flight reserves a FIFO slot, so in_ready never overcommits.
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, cap_pending};
  assign in_ready    = (state == STREAM) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign pool_clk_en = in_valid && in_ready;
  assign pool_in_data = in_data;

  assign frame_start = (state == IDLE) && start;
  assign last_accept = pool_clk_en && (in_cnt == IN_CW'(N_IN - 1));
  assign capture     = cap_pending && pool_valid;
  assign push        = capture && (out_cnt != OUT_CW'(N_OUT));
  assign last_cap    = (out_cnt == OUT_CW'(N_OUT - 1));
  assign fifo_empty  = (fifo_count == '0);
  assign pop         = out_valid && out_ready;

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = !fifo_empty;
  assign out_data  = head[W-1:0];
  assign out_last  = out_valid && head[W];
  assign busy      = (state == STREAM) || (state == DRAIN);
  assign done      = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: if (last_accept) state_nxt = DRAIN;
      DRAIN:  if ((out_cnt == OUT_CW'(N_OUT)) && fifo_empty) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The layer answers one cycle after each clk_en pulse; only that cycle's pool_valid is trusted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt      <= '0;
      out_cnt     <= '0;
      cap_pending <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      cap_pending <= pool_clk_en;
      if (frame_start) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        ovf     <= 1'b0;
      end else begin
        if (pool_clk_en && !last_accept) in_cnt <= in_cnt + IN_CW'(1);
        if (push) out_cnt <= out_cnt + OUT_CW'(1);
        if (capture && !push) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {last_cap, pool_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef POOL_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || frame_start) begin
      stall_cycles <= '0;
      frame_cycles <= '0;
    end else begin
      if ((state == STREAM) && in_valid && !in_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if ((state != IDLE) && (frame_cycles != '1))
        frame_cycles <= frame_cycles + 32'd1;
    end
  end

  assign overflow = ovf;
`endif

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Bench for pool_stream_ctrl: reset/start vector table, then randomized frames scored against
// a window-level pooling model and an expected-output queue. Perf outputs checked under POOL_CTRL_PERF_EN.
module tb_pool_stream_ctrl;

  localparam int CHANNELS    = 5;
  localparam int I_WIDTH     = 16;
  localparam int IMAGE_SIZE  = 15;
  localparam int FILTER_SIZE = 2;
  localparam int STRIDE      = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int W        = CHANNELS * I_WIDTH;
  localparam int N_IN     = IMAGE_SIZE * IMAGE_SIZE;
  localparam int OUT_SIDE = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int N_OUT    = OUT_SIDE * OUT_SIDE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] pool_data = '0;
  logic         pool_valid = 1'b0;
  logic         in_ready, pool_clk_en, out_valid, out_last, busy, done;
  logic [W-1:0] pool_in_data, out_data;
`ifdef POOL_CTRL_PERF_EN
  logic [31:0]  stall_cycles, frame_cycles;
  logic         overflow;
`endif

  pool_stream_ctrl #(
    .CHANNELS(CHANNELS), .I_WIDTH(I_WIDTH), .IMAGE_SIZE(IMAGE_SIZE),
    .FILTER_SIZE(FILTER_SIZE), .STRIDE(STRIDE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pool_clk_en(pool_clk_en), .pool_in_data(pool_in_data),
    .pool_data(pool_data), .pool_valid(pool_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef POOL_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .frame_cycles(frame_cycles), .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    bit           last;
  } beat_t;

  typedef struct {
    bit rst_n, start, in_valid;
    bit in_ready, busy, done, out_valid, clk_en;
  } vec_t;

  beat_t expq[$];
  beat_t mon_e;
  int    checks = 0;
  int    failures = 0;
  int    en_cnt, beat_cnt, done_cnt, cap_cnt, occ, fc;
  bit    prev_en, counting, hold_v, noise_en, all_valid;
  logic [W-1:0] hold_d;
  int    pcnt;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < CHANNELS; i++) w[i*I_WIDTH +: I_WIDTH] = I_WIDTH'($urandom);
    return w;
  endfunction

  function automatic logic [W-1:0] pool_fn(input logic [W-1:0] x);
    return x ^ {CHANNELS{16'hA5C3}};
  endfunction

  // Pixel k (raster order) closes a pooling window when it is the bottom-right corner of one.
  function automatic bit window_done(input int k);
    int r, c;
    r = k / IMAGE_SIZE - (FILTER_SIZE - 1);
    c = k % IMAGE_SIZE - (FILTER_SIZE - 1);
    return (r >= 0) && (c >= 0) && (r % STRIDE == 0) && (c % STRIDE == 0) &&
           (r / STRIDE < OUT_SIDE) && (c / STRIDE < OUT_SIDE);
  endfunction

  // Stand-in pooling layer: answers one cycle after each clk_en pulse, optional junk otherwise.
  always @(posedge clk) begin
    if (!rst_n) begin
      pool_valid <= 1'b0;
      pcnt       <= 0;
    end else if (pool_clk_en) begin
      pool_valid <= all_valid || window_done(pcnt);
      pool_data  <= pool_fn(pool_in_data);
      pcnt       <= (pcnt == N_IN - 1) ? 0 : pcnt + 1;
    end else begin
      pool_valid <= noise_en && ($urandom_range(0, 1) == 1);
      pool_data  <= rand_word();
    end
  end

  // Monitor: scores every output beat, tracks expected FIFO occupancy and frame events.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ     = 0;
      prev_en = 1'b0;
      hold_v  = 1'b0;
    end else begin
      checkOutput("clk_en_rule", 128'(pool_clk_en), 128'(in_valid && in_ready));
      if (pool_clk_en) begin
        en_cnt++;
        checkOutput("pool_in_data", 128'(pool_in_data), 128'(in_data));
      end
      if (hold_v) begin
        checkOutput("hold_valid", 128'(out_valid), 128'(1));
        checkOutput("hold_data", 128'(out_data), 128'(hold_d));
      end
      checkOutput("out_valid", 128'(out_valid), 128'(occ != 0));
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (occ > 0) occ--;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL extra_beat: got beat %0d data %0h, expected none", beat_cnt, out_data);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("out_data", 128'(out_data), 128'(mon_e.data));
          checkOutput("out_last", 128'(out_last), 128'(mon_e.last));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (prev_en && pool_valid) begin
        if (cap_cnt < N_OUT) begin
          checkOutput("push_not_full", 128'(occ < FIFO_DEPTH), 128'(1));
          occ++;
        end
        cap_cnt++;
      end
      prev_en = pool_clk_en;
      if (counting) fc++;
      if (done) begin
        done_cnt++;
        counting = 1'b0;
        checkOutput("busy_in_finish", 128'(busy), 128'(0));
      end
    end
  end

  // One frame: build the pixel set and expected outputs, then drive valid/ready per cycle.
  task automatic applyStimulus(input int valid_pct, input int ready_pct, input int hold,
                               input int stall_limit, input int start_again, input int abort_at,
                               input bit noise, input bit allv);
    logic [W-1:0] px [N_IN];
    int  k, cyc, stalls, outn;
    bit  acc, quiet;
    expq.delete();
    outn = 0;
    for (int i = 0; i < N_IN; i++) begin
      px[i] = rand_word();
      if (allv ? (i < N_OUT) : window_done(i)) begin
        expq.push_back('{pool_fn(px[i]), outn == N_OUT - 1});
        outn++;
      end
    end
    noise_en = noise;
    all_valid = allv;
    en_cnt = 0; beat_cnt = 0; done_cnt = 0; cap_cnt = 0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; fc = 0; counting = 1'b1;
    k = 0; cyc = 0; stalls = 0;
    while (done_cnt == 0 && cyc < 6000) begin
      if (abort_at >= 0 && k == abort_at) begin
        in_valid = 1'b0; rst_n = 1'b0; counting = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("abort_busy", 128'(busy), 128'(0));
        checkOutput("abort_in_ready", 128'(in_ready), 128'(0));
        checkOutput("abort_out_valid", 128'(out_valid), 128'(0));
        rst_n = 1'b1;
        expq.delete();
        repeat (6) begin @(posedge clk); #1; end
        checkOutput("abort_no_done", 128'(done_cnt), 128'(0));
        return;
      end
      quiet = (stall_limit >= 0) && (stalls >= stall_limit) && (cyc <= hold);
      in_valid  = (k < N_IN) && !quiet && ($urandom_range(1, 100) <= valid_pct);
      in_data   = (k < N_IN) ? px[k] : rand_word();
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(1, 100) <= ready_pct);
      start     = (cyc == start_again);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      if (hold > 0 && cyc == hold - 1) begin
        checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
        checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
        checkOutput("bp_fifo_level", 128'(occ), 128'(FIFO_DEPTH));
      end
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    checkOutput("frame_timeout", 128'(done_cnt != 0), 128'(1));
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("done_pulses", 128'(done_cnt), 128'(1));
    checkOutput("clk_en_pulses", 128'(en_cnt), 128'(N_IN));
    checkOutput("out_beats", 128'(beat_cnt), 128'(N_OUT));
    checkOutput("exp_left", 128'(expq.size()), 128'(0));
    checkOutput("busy_after", 128'(busy), 128'(0));
    checkOutput("out_valid_after", 128'(out_valid), 128'(0));
`ifdef POOL_CTRL_PERF_EN
    checkOutput("stall_cycles", 128'(stall_cycles), 128'((stall_limit >= 0) ? stall_limit : stalls));
    checkOutput("frame_cycles", 128'(frame_cycles), 128'(fc));
    checkOutput("overflow", 128'(overflow), 128'(allv));
`endif
  endtask

  vec_t vecs [8];

  initial begin
    // rst_n start in_valid | in_ready busy done out_valid clk_en (observed just after the edge)
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 1, 1, 1, 1, 0, 0, 1};
    vecs[4] = '{1, 0, 0, 1, 1, 0, 0, 0};
    vecs[5] = '{1, 1, 0, 1, 1, 0, 0, 0};
    vecs[6] = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 0, 0, 0, 0};

    noise_en = 1'b0; all_valid = 1'b0; counting = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rst_n    = vecs[i].rst_n;
      start    = vecs[i].start;
      in_valid = vecs[i].in_valid;
      in_data  = rand_word();
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].in_ready));
      checkOutput($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_done", i), 128'(done), 128'(vecs[i].done));
      checkOutput($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].out_valid));
      checkOutput($sformatf("vec%0d_clk_en", i), 128'(pool_clk_en), 128'(vecs[i].clk_en));
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] full frame, no backpressure");
    applyStimulus(100, 100, 0, -1, -1, -1, 1'b0, 1'b0);
    $display("[TB] backpressure hold with 10 stall cycles");
    applyStimulus(100, 100, 60, 10, -1, -1, 1'b0, 1'b0);
    $display("[TB] input bubbles with stray pool_valid");
    applyStimulus(50, 100, 0, -1, -1, -1, 1'b1, 1'b0);
    $display("[TB] start while busy");
    applyStimulus(70, 70, 0, -1, 50, -1, 1'b1, 1'b0);
    $display("[TB] reset at pixel 100, then a clean frame");
    applyStimulus(100, 60, 0, -1, -1, 100, 1'b0, 1'b0);
    applyStimulus(100, 100, 0, -1, -1, -1, 1'b0, 1'b0);
    $display("[TB] surplus captures beyond the frame");
    applyStimulus(80, 80, 0, -1, -1, -1, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      $display("[TB] random frame %0d", f);
      applyStimulus($urandom_range(30, 100), $urandom_range(30, 100), 0, -1, -1, -1,
                    1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
